// File: rtl/spi_slave_i.sv
// spi_slave_i: oversampling SPI slave that recovers DAC frames (SYNC/SCLK/SDI)
// and flags short (abort) and long (overflow) frames.
`default_nettype none

module spi_slave_i #(
  parameter int DATA_WIDTH  = 24,
  parameter int CODE_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sync_i,
  input  logic                  sclk_i,
  input  logic                  sdi_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CODE_WIDTH-1:0] code_o,
  output logic                  valid_o,
  output logic                  abort_o,
  output logic                  ovf_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  frame_cnt_o
);

  localparam int BC_W = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sr, sync_sr, sdi_sr;
  logic                   sclk_s, sync_s, sdi_s;
  logic                   sclk_q, sync_q;
  logic                   sclk_fall_r, sync_fall_r, sync_rise_r, sdi_r;

  logic [1:0]             state, state_next;
  logic [BC_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]  shreg, shift_next;
  logic [CNT_WIDTH-1:0]   frame_cnt;

  logic                   last_bit, do_shift, frame_done, abort_next, ovf_next;

  // Identical chains keep sclk/sync/sdi aligned; cleared to the bus idle level.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sclk_sr <= '1;
      sync_sr <= '1;
      sdi_sr  <= '0;
      sclk_q  <= 1'b1;
      sync_q  <= 1'b1;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk_i};
      sync_sr <= {sync_sr[SYNC_STAGES-2:0], sync_i};
      sdi_sr  <= {sdi_sr[SYNC_STAGES-2:0], sdi_i};
      sclk_q  <= sclk_s;
      sync_q  <= sync_s;
    end
  end

  assign sclk_s = sclk_sr[SYNC_STAGES-1];
  assign sync_s = sync_sr[SYNC_STAGES-1];
  assign sdi_s  = sdi_sr[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sclk_fall_r <= 1'b0;
      sync_fall_r <= 1'b0;
      sync_rise_r <= 1'b0;
      sdi_r       <= 1'b0;
    end else begin
      sclk_fall_r <= sclk_q & ~sclk_s;
      sync_fall_r <= sync_q & ~sync_s;
      sync_rise_r <= ~sync_q & sync_s;
      sdi_r       <= sdi_s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_next;
  end

  assign last_bit = (bit_cnt == BC_W'(DATA_WIDTH - 1));

  // A coincident sclk fall is handled before sync rise; a completing bit wins.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (sync_fall_r) state_next = S_SHIFT;
      S_SHIFT: begin
        if (sync_rise_r)                   state_next = S_IDLE;
        else if (sclk_fall_r && last_bit)  state_next = S_DONE;
      end
      S_DONE:  if (sync_rise_r) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    do_shift   = (state == S_SHIFT) && sclk_fall_r;
    frame_done = do_shift && last_bit;
    abort_next = (state == S_SHIFT) && sync_rise_r && !frame_done;
    ovf_next   = (state == S_DONE) && sclk_fall_r;
    shift_next = {shreg[DATA_WIDTH-2:0], sdi_r};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      data_o    <= '0;
      code_o    <= '0;
      frame_cnt <= '0;
      valid_o   <= 1'b0;
      abort_o   <= 1'b0;
      ovf_o     <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      valid_o <= frame_done;
      abort_o <= abort_next;
      ovf_o   <= ovf_next;
      busy_o  <= (state_next != S_IDLE);
      if (state == S_IDLE && sync_fall_r) bit_cnt <= '0;
      if (do_shift) begin
        shreg   <= shift_next;
        bit_cnt <= bit_cnt + BC_W'(1);
      end
      if (frame_done) begin
        data_o    <= shift_next;
        code_o    <= shift_next[CODE_WIDTH-1:0];
        frame_cnt <= frame_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign frame_cnt_o = frame_cnt;

endmodule

`default_nettype wire
